// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREGS x WIDTH accumulator ALU with shared status and an iterative multiply
// Optional rotate opcodes D/E are enabled by defining ALU_ROTATE_EN.
module alu_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               opcode,
  input  logic [$clog2(NREGS)-1:0] reg_sel,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     out_valid
);

  localparam int RW = $clog2(NREGS);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   acc [NREGS];
  logic [3:0]         status;
  logic [WIDTH-1:0]   acc_cur;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     mul_sum;
  logic [CW-1:0]      mul_cnt;
  logic [RW-1:0]      mul_sel;
  logic               mul_last;

  logic [WIDTH:0]     sum, diff, sh_l, sh_r;
  logic [WIDTH-1:0]   res;
  logic               res_c, res_v, upd_flags, show_status;
  logic [3:0]         new_status;
  logic [WIDTH-1:0]   mul_lo, mul_hi;

`ifdef ALU_ROTATE_EN
  logic [31:0]        rot_amt;
  assign rot_amt = 32'(data_in) % 32'(WIDTH);
`endif

  assign acc_cur  = acc[reg_sel];
  assign in_ready = (state == S_IDLE);

  assign sum  = {1'b0, acc_cur} + {1'b0, data_in};
  assign diff = {1'b0, acc_cur} - {1'b0, data_in};
  // The extra bit on each side catches the last bit shifted out; large amounts flush to zero.
  assign sh_l = {1'b0, acc_cur} << data_in;
  assign sh_r = {acc_cur, 1'b0} >> data_in;

  // Shift-add: add multiplicand into the high half when the current multiplier bit is set.
  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_step = {mul_sum, prod[WIDTH-1:1]};
  assign mul_lo    = prod_step[WIDTH-1:0];
  assign mul_hi    = prod_step[2*WIDTH-1:WIDTH];
  assign mul_last  = (mul_cnt == CW'(WIDTH - 1));

  always_comb begin
    res         = acc_cur;
    res_c       = 1'b0;
    res_v       = 1'b0;
    upd_flags   = 1'b0;
    show_status = 1'b0;
    case (opcode)
      4'h1: begin res = data_in; upd_flags = 1'b1; end
      4'h2: begin
        res       = sum[WIDTH-1:0];
        res_c     = sum[WIDTH];
        res_v     = (acc_cur[WIDTH-1] == data_in[WIDTH-1]) && (sum[WIDTH-1] != acc_cur[WIDTH-1]);
        upd_flags = 1'b1;
      end
      4'h3: begin
        res       = diff[WIDTH-1:0];
        res_c     = diff[WIDTH];
        res_v     = (acc_cur[WIDTH-1] != data_in[WIDTH-1]) && (diff[WIDTH-1] != acc_cur[WIDTH-1]);
        upd_flags = 1'b1;
      end
      4'h4: begin res = '0;                upd_flags = 1'b1; end
      4'h5: begin res = WIDTH'(1);         upd_flags = 1'b1; end
      4'h6: begin res = acc_cur ^ data_in; upd_flags = 1'b1; end
      4'h7: begin res = ~acc_cur;          upd_flags = 1'b1; end
      4'hA: begin res = acc_cur & data_in; upd_flags = 1'b1; end
      4'hB: begin res = acc_cur | data_in; upd_flags = 1'b1; end
      4'h8: begin res = sh_l[WIDTH-1:0]; res_c = sh_l[WIDTH]; upd_flags = 1'b1; end
      4'h9: begin res = sh_r[WIDTH:1];   res_c = sh_r[0];     upd_flags = 1'b1; end
`ifdef ALU_ROTATE_EN
      // The last wrapped bit lands at the far end of the result.
      4'hD: begin
        res       = (acc_cur << rot_amt) | (acc_cur >> (32'(WIDTH) - rot_amt));
        res_c     = (rot_amt != 0) && res[0];
        upd_flags = 1'b1;
      end
      4'hE: begin
        res       = (acc_cur >> rot_amt) | (acc_cur << (32'(WIDTH) - rot_amt));
        res_c     = (rot_amt != 0) && res[WIDTH-1];
        upd_flags = 1'b1;
      end
`endif
      4'hF: show_status = 1'b1;
      default: ;
    endcase
    new_status = {res_v, res_c, res[WIDTH-1], (res == '0)};
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid && opcode == 4'hC) state_next = S_MUL;
      S_MUL:  if (mul_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) acc[i] <= '0;
      status    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      mcand     <= '0;
      prod      <= '0;
      mul_cnt   <= '0;
      mul_sel   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (in_valid) begin
          if (opcode == 4'hC) begin
            mcand   <= acc_cur;
            prod    <= {{WIDTH{1'b0}}, data_in};
            mul_cnt <= '0;
            mul_sel <= reg_sel;
          end else begin
            acc[reg_sel] <= res;
            if (upd_flags) status <= new_status;
            data_out  <= show_status ? WIDTH'(status) : res;
            out_valid <= 1'b1;
          end
        end
      end else begin
        prod    <= prod_step;
        mul_cnt <= mul_cnt + 1'b1;
        if (mul_last) begin
          acc[mul_sel] <= mul_lo;
          status       <= {1'b0, (mul_hi != '0), mul_lo[WIDTH-1], (mul_lo == '0)};
          data_out     <= mul_lo;
          out_valid    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_regfile.sv
// tb/tb_alu_regfile.sv - directed scoreboard bench for alu_regfile (WIDTH=8, NREGS=4)
module tb_alu_regfile;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] opcode = '0;
  logic [1:0] reg_sel = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       out_valid;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_regfile #(.WIDTH(8), .NREGS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .reg_sel   (reg_sel),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every out_valid pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.tag, 32'(data_out), 32'(e.val));
      end
    end
  end

  task automatic op(input logic [3:0] opc, input logic [1:0] r, input logic [7:0] d,
                    input logic [7:0] e, input string tag, input bit expect_out);
    int n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    end else begin
      opcode   = opc;
      reg_sel  = r;
      data_in  = d;
      in_valid = 1'b1;
      if (expect_out) begin
        x.tag = tag;
        x.val = e;
        exp_q.push_back(x);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    for (int i = 0; i < 4; i++) op(4'h0, 2'(i), 8'h00, 8'h00, "rst_nop", 1'b1);
    op(4'hF, 2'd0, 8'h00, 8'h00, "rst_status", 1'b1);

    op(4'h1, 2'd1, 8'h80, 8'h80, "load_r1", 1'b1);
    op(4'h2, 2'd1, 8'h80, 8'h00, "add_ovf", 1'b1);
    op(4'hF, 2'd1, 8'h00, 8'h0D, "add_ovf_status", 1'b1);

    op(4'h1, 2'd0, 8'h03, 8'h03, "load_r0", 1'b1);
    op(4'h3, 2'd0, 8'h05, 8'hFE, "sub_borrow", 1'b1);
    op(4'hF, 2'd0, 8'h00, 8'h06, "sub_status", 1'b1);
    op(4'h2, 2'd0, 8'h03, 8'h01, "add_plain", 1'b1);
    op(4'hF, 2'd0, 8'h00, 8'h04, "add_plain_status", 1'b1);

    op(4'h1, 2'd0, 8'h10, 8'h10, "load_mul", 1'b1);
    op(4'hC, 2'd0, 8'h20, 8'h00, "mul_result", 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("mul_busy", 32'(in_ready), 32'd0);
      check("mul_no_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("mul_done_ready", 32'(in_ready), 32'd1);
    check("mul_done_valid", 32'(out_valid), 32'd1);
    op(4'hF, 2'd0, 8'h00, 8'h05, "mul_status", 1'b1);
    op(4'h1, 2'd2, 8'h55, 8'h55, "load_r2", 1'b1);
    op(4'h1, 2'd3, 8'hAA, 8'hAA, "load_r3", 1'b1);
    op(4'h0, 2'd2, 8'h00, 8'h55, "nop_r2", 1'b1);
    op(4'h0, 2'd1, 8'h00, 8'h00, "nop_r1", 1'b1);
    op(4'h1, 2'd2, 8'h0D, 8'h0D, "load_r2_b", 1'b1);
    op(4'hC, 2'd2, 8'h0B, 8'h8F, "mul_small", 1'b1);
    op(4'hF, 2'd2, 8'h00, 8'h02, "mul_small_status", 1'b1);

    op(4'h1, 2'd1, 8'h81, 8'h81, "load_shl", 1'b1);
    op(4'h8, 2'd1, 8'h01, 8'h02, "shl_1", 1'b1);
    op(4'hF, 2'd1, 8'h00, 8'h04, "shl_1_status", 1'b1);
    op(4'h8, 2'd1, 8'h09, 8'h00, "shl_9", 1'b1);
    op(4'hF, 2'd1, 8'h00, 8'h01, "shl_9_status", 1'b1);
    op(4'h1, 2'd1, 8'h81, 8'h81, "load_shr", 1'b1);
    op(4'h9, 2'd1, 8'h00, 8'h81, "shr_0", 1'b1);
    op(4'hF, 2'd1, 8'h00, 8'h02, "shr_0_status", 1'b1);
    op(4'h9, 2'd1, 8'h08, 8'h00, "shr_8", 1'b1);
    op(4'hF, 2'd1, 8'h00, 8'h05, "shr_8_status", 1'b1);
    op(4'h4, 2'd3, 8'h00, 8'h00, "zero_r3", 1'b1);
    op(4'h5, 2'd3, 8'h00, 8'h01, "one_r3", 1'b1);
    op(4'h6, 2'd3, 8'hFF, 8'hFE, "xor_r3", 1'b1);
    op(4'h7, 2'd3, 8'h00, 8'h01, "not_r3", 1'b1);

    op(4'h1, 2'd1, 8'h81, 8'h81, "load_rot", 1'b1);
`ifdef ALU_ROTATE_EN
    op(4'hD, 2'd1, 8'h01, 8'h03, "rol_1", 1'b1);
    op(4'hF, 2'd1, 8'h00, 8'h04, "rol_1_status", 1'b1);
`else
    op(4'hD, 2'd1, 8'h01, 8'h81, "opc_d_read", 1'b1);
    op(4'hF, 2'd1, 8'h00, 8'h02, "opc_d_status", 1'b1);
`endif

    op(4'h1, 2'd0, 8'h10, 8'h10, "load_abort", 1'b1);
    op(4'hC, 2'd0, 8'h20, 8'h00, "mul_abort", 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_data_out", 32'(data_out), 32'd0);
    for (int i = 0; i < 4; i++) op(4'h0, 2'(i), 8'h00, 8'h00, "abort_nop", 1'b1);
    op(4'hF, 2'd0, 8'h00, 8'h00, "abort_status", 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
